// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared state encoding and default widths for the data-memory arbiter
package dm_arb_pkg;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 4;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: core, host and data-memory nets seen by the arbiter
interface dm_arbiter_if #(
   parameter int ADDR_W = dm_arb_pkg::DEF_ADDR_W,
   parameter int DATA_W = dm_arb_pkg::DEF_DATA_W
);
   logic              core_access;
   logic              core_wren;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_hold;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_busy;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;
   modport slave (
      input  core_access, core_wren, core_addr, core_wdata,
      input  host_req, host_we, host_addr, host_wdata, mem_q,
      output core_rdata, core_hold, host_busy, host_ack, host_rdata,
      output mem_addr, mem_data, mem_wren
   );
   modport master (
      output core_access, core_wren, core_addr, core_wdata,
      output host_req, host_we, host_addr, host_wdata, mem_q,
      input  core_rdata, core_hold, host_busy, host_ack, host_rdata,
      input  mem_addr, mem_data, mem_wren
   );
endinterface

// File: rtl/dm_arb_starve_ctr.sv
// dm_arb_starve_ctr: counts core-blocked wait cycles and forces one host grant at MAX_WAIT
module dm_arb_starve_ctr #(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic sync_reset,
   input  logic in_wait,
   input  logic core_own,
   input  logic clr,
   output logic forced
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (sync_reset || clr)
         cnt <= '0;
      else if (core_own && cnt != CW'(MAX_WAIT))
         cnt <= cnt + CW'(1);
   end
   assign forced = in_wait && cnt == CW'(MAX_WAIT);
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: core-priority sharing of the data memory with a one-deep host port
// HOST_STARVE_GUARD_EN enables the forced host grant after MAX_WAIT blocked cycles.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = 8
) (
   input logic         clk,
   input logic         sync_reset,
   dm_arbiter_if.slave bus
);
   state_t            state, state_n;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              core_own, forced, host_go;
   assign core_own = bus.core_access | bus.core_wren;
   // a reset cycle never lets a discarded host access reach the memory
   assign host_go = state == WAIT && !sync_reset && (!core_own || forced);
`ifdef HOST_STARVE_GUARD_EN
   logic forced_raw;
   dm_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve_ctr (
      .clk       (clk),
      .sync_reset(sync_reset),
      .in_wait   (state == WAIT),
      .core_own  (core_own),
      .clr       (state != WAIT || host_go),
      .forced    (forced_raw)
   );
   assign forced = forced_raw & ~sync_reset;
`else
   assign forced = 1'b0;
`endif
   always_comb begin
      state_n        = state;
      bus.mem_addr   = host_go ? addr_q : bus.core_addr;
      bus.mem_data   = host_go ? wdata_q : bus.core_wdata;
      bus.mem_wren   = host_go ? we_q : bus.core_wren;
      bus.core_rdata = bus.mem_q;
      bus.core_hold  = forced;
      bus.host_busy  = state != IDLE;
      bus.host_ack   = state == DONE;
      bus.host_rdata = rdata_q;
      state_n = state == IDLE ? (bus.host_req ? WAIT : IDLE) :
                state == WAIT ? (host_go ? DONE : WAIT) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && bus.host_req) begin
            we_q    <= bus.host_we;
            addr_q  <= bus.host_addr;
            wdata_q <= bus.host_wdata;
         end
         if (host_go && !we_q)
            rdata_q <= bus.mem_q;
      end
   end
endmodule
